fetch_sequencer: RTL and testbench

Front-end fetch controller that sequences the instruction buffer's input side. Owns the fetch PC, issues 2-instruction bundle requests to instruction memory under a credit limit, holds in-order responses in a small response queue, and delivers them to the instruction buffer, honouring its `stall_if` backpressure. On a backend redirect it flushes the instruction buffer and its own queue, retargets the PC, and silently discards responses from requests already in flight.

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner, credit-limited imem requester and in-order response queue
module fetch_sequencer #(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         INST_WIDTH      = 32,
    parameter int                         IF_BATCH_SIZE   = 2,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                         MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   fetch_en,
    input  logic                                   redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0]             redirect_pc,
    output logic                                   imem_req_valid,
    output logic [INST_ADDR_WIDTH-1:0]             imem_req_pc,
    input  logic                                   imem_req_ready,
    input  logic                                   imem_resp_valid,
    input  logic [INST_WIDTH-1:0]                  imem_resp_inst_0,
    input  logic [INST_WIDTH-1:0]                  imem_resp_inst_1,
    input  logic                                   ib_stall,
    output logic                                   ib_flush,
    output logic [IF_BATCH_SIZE-1:0]               out_valid,
    output logic [INST_WIDTH-1:0]                  out_inst_0,
    output logic [INST_WIDTH-1:0]                  out_inst_1,
    output logic [INST_ADDR_WIDTH-1:0]             out_pc_0,
    output logic [INST_ADDR_WIDTH-1:0]             out_pc_1,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   inflight
);

    localparam int AW = INST_ADDR_WIDTH;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   kill_q, kill_d;
    logic [CW-1:0]   q_count_q, q_count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;

    logic [INST_WIDTH-1:0] q_inst0_q [MAX_OUTSTANDING];
    logic [INST_WIDTH-1:0] q_inst1_q [MAX_OUTSTANDING];
    logic [AW-1:0]         q_pc_q    [MAX_OUTSTANDING];

    logic          credit_ok;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          out_vld;
    logic [CW:0]   credit_used;
    logic [AW-1:0] redirect_base;
    logic          unused_redirect_lsbs;

    // Queue pointers wrap at the queue depth, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redirect_base        = {redirect_pc[AW-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign credit_used          = {1'b0, inflight_q} + {1'b0, q_count_q};
    assign credit_ok            = credit_used < (CW+1)'(MAX_OUTSTANDING);

    // Next-state, request/delivery handshakes and all counter updates; a redirect wins over everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        kill_d     = kill_q;
        q_count_d  = q_count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        case (state_q)
            S_IDLE:  if (fetch_en)  state_d = S_RUN;
            S_RUN:   if (!fetch_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        imem_req_valid = (state_q == S_RUN) && credit_ok && !redirect_valid;
        req_fire       = imem_req_valid && imem_req_ready;
        out_vld        = (q_count_q != '0) && !redirect_valid;
        pop            = out_vld && !ib_stall;
        push           = imem_resp_valid && (kill_q == '0) && !redirect_valid;

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path; a response landing now is dropped too.
            pc_d       = redirect_base;
            resp_pc_d  = redirect_base;
            inflight_d = inflight_q - CW'(imem_resp_valid);
            kill_d     = inflight_q - CW'(imem_resp_valid);
            q_count_d  = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (req_fire) pc_d = pc_q + AW'(8);
            inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (kill_q != '0)) kill_d = kill_q - CW'(1);
            if (push) begin
                resp_pc_d = resp_pc_q + AW'(8);
                tail_d    = ptr_inc(tail_q);
            end
            if (pop) head_d = ptr_inc(head_q);
            q_count_d = q_count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            kill_q     <= '0;
            q_count_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            q_count_q  <= q_count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue payload; left unreset because every read is gated by q_count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst0_q[tail_q] <= imem_resp_inst_0;
            q_inst1_q[tail_q] <= imem_resp_inst_1;
            q_pc_q[tail_q]    <= resp_pc_q;
        end
    end

    assign ib_flush    = redirect_valid;
    assign imem_req_pc = pc_q;
    assign inflight    = inflight_q;
    assign out_valid   = {IF_BATCH_SIZE{out_vld}};
    assign out_inst_0  = out_vld ? q_inst0_q[head_q] : '0;
    assign out_inst_1  = out_vld ? q_inst1_q[head_q] : '0;
    assign out_pc_0    = out_vld ? q_pc_q[head_q] : '0;
    assign out_pc_1    = out_vld ? q_pc_q[head_q] + AW'(4) : '0;

    // A push into a full queue means the credit accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (q_count_q == CW'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int          AW       = 32;
    localparam int          IW       = 32;
    localparam int          MO       = 2;
    localparam int          CW       = $clog2(MO + 1);
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           fetch_en = 1'b0;
    logic           redirect_valid = 1'b0;
    logic [AW-1:0]  redirect_pc = '0;
    logic           imem_req_valid;
    logic [AW-1:0]  imem_req_pc;
    logic           imem_req_ready = 1'b1;
    logic           imem_resp_valid = 1'b0;
    logic [IW-1:0]  imem_resp_inst_0 = '0;
    logic [IW-1:0]  imem_resp_inst_1 = '0;
    logic           ib_stall = 1'b0;
    logic           ib_flush;
    logic [1:0]     out_valid;
    logic [IW-1:0]  out_inst_0;
    logic [IW-1:0]  out_inst_1;
    logic [AW-1:0]  out_pc_0;
    logic [AW-1:0]  out_pc_1;
    logic [CW-1:0]  inflight;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            lat = 1;
    int            drop_cnt = 0;
    logic [AW-1:0] exp_req_pc = RESET_PC;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] pend_pc [$];
    int            pend_due [$];
    logic [AW-1:0] resp_a;
    logic [AW-1:0] mon_e;

    fetch_sequencer #(
        .INST_ADDR_WIDTH (AW),
        .INST_WIDTH      (IW),
        .IF_BATCH_SIZE   (2),
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_pc      (imem_req_pc),
        .imem_req_ready   (imem_req_ready),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_inst_0 (imem_resp_inst_0),
        .imem_resp_inst_1 (imem_resp_inst_1),
        .ib_stall         (ib_stall),
        .ib_flush         (ib_flush),
        .out_valid        (out_valid),
        .out_inst_0       (out_inst_0),
        .out_inst_1       (out_inst_1),
        .out_pc_0         (out_pc_0),
        .out_pc_1         (out_pc_1),
        .inflight         (inflight)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // imem model, response side: responses appear lat cycles after the request fired.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        imem_resp_valid  = 1'b0;
        imem_resp_inst_0 = '0;
        imem_resp_inst_1 = '0;
        if (rst_n && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            resp_a = pend_pc.pop_front();
            void'(pend_due.pop_front());
            imem_resp_valid  = 1'b1;
            imem_resp_inst_0 = inst_of(resp_a);
            imem_resp_inst_1 = inst_of(resp_a + 32'd4);
            if (drop_cnt > 0) drop_cnt--;
            else exp_q.push_back(resp_a);
        end
    end

    // Request capture and output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ib_flush", {31'd0, ib_flush}, {31'd0, redirect_valid});
            if (imem_req_valid && imem_req_ready) begin
                chk("req_pc", imem_req_pc, exp_req_pc);
                pend_pc.push_back(exp_req_pc);
                pend_due.push_back(cyc + lat);
                exp_req_pc = exp_req_pc + 32'd8;
            end
            if (out_valid[0]) begin
                chk("out_valid_pair", {30'd0, out_valid}, 32'd3);
                if (!ib_stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bundle: got pc %0h expected none", out_pc_0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_pc_0", out_pc_0, mon_e);
                        chk("out_pc_1", out_pc_1, mon_e + 32'd4);
                        chk("out_inst_0", out_inst_0, inst_of(mon_e));
                        chk("out_inst_1", out_inst_1, inst_of(mon_e + 32'd4));
                    end
                end
            end else begin
                chk("out_valid_low", {30'd0, out_valid}, 32'd0);
                chk("idle_data", out_pc_0 | out_pc_1 | out_inst_0 | out_inst_1, 32'd0);
            end
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ib_stall       = 1'b0;
        imem_req_ready = 1'b1;
        exp_q.delete();
        pend_pc.delete();
        pend_due.delete();
        drop_cnt   = 0;
        exp_req_pc = RESET_PC;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_pc", imem_req_pc, RESET_PC);
        chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_pc_0 | out_pc_1 | out_inst_0 | out_inst_1, 32'd0);
        chk("rst_ib_flush", {31'd0, ib_flush}, 32'd0);
        chk("rst_inflight", {30'd0, inflight}, 32'd0);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        fetch_en = 1'b0;
        ib_stall = 1'b0;
        tick(12);
        chk("drain_scoreboard", exp_q.size(), 32'd0);
        chk("drain_pending", pend_pc.size(), 32'd0);
        chk("drain_inflight", {30'd0, inflight}, 32'd0);
    endtask

    initial begin
        // Basic fetch, 1-cycle imem.
        do_reset();
        lat = 1;
        tick(1);
        fetch_en = 1'b1;
        #1 chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick(1);
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_pc", imem_req_pc, 32'h0);
        tick(10);
        drain();

        // Backpressure: queue fills to credit limit and holds.
        do_reset();
        lat = 1;
        tick(1);
        fetch_en = 1'b1;
        ib_stall = 1'b1;
        tick(3);
        chk("bp_i3_req", {31'd0, imem_req_valid}, 32'd0);
        chk("bp_i3_inflight", {30'd0, inflight}, 32'd1);
        tick(2);
        chk("bp_i5_req", {31'd0, imem_req_valid}, 32'd0);
        chk("bp_i5_inflight", {30'd0, inflight}, 32'd0);
        chk("bp_i5_out_valid", {30'd0, out_valid}, 32'd3);
        chk("bp_i5_head", out_pc_0, 32'h0);
        ib_stall = 1'b0;
        tick(6);
        drain();

        // Request stall: ready low holds the request.
        do_reset();
        lat = 1;
        tick(1);
        fetch_en       = 1'b1;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("hold_pc", imem_req_pc, 32'h0);
            chk("hold_inflight", {30'd0, inflight}, 32'd0);
        end
        imem_req_ready = 1'b1;
        tick(4);
        drain();

        // Redirect with two requests in flight (3-cycle imem).
        do_reset();
        lat = 3;
        tick(1);
        fetch_en = 1'b1;
        tick(3);
        chk("rd_inflight", {30'd0, inflight}, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        exp_q.delete();
        drop_cnt   = 2;
        exp_req_pc = 32'h0000_0100;
        #1 chk("rd_flush", {31'd0, ib_flush}, 32'd1);
        chk("rd_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick(1);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1 chk("rd_flush_off", {31'd0, ib_flush}, 32'd0);
        chk("rd_target_pc", imem_req_pc, 32'h0000_0100);
        chk("rd_inflight_n1", {30'd0, inflight}, 32'd2);
        tick(8);
        drain();

        // Redirect with a response in the same cycle (2-cycle imem, one request).
        do_reset();
        lat = 2;
        tick(1);
        fetch_en = 1'b1;
        tick(1);
        fetch_en = 1'b0;
        tick(2);
        chk("sc_inflight", {30'd0, inflight}, 32'd1);
        chk("sc_resp_present", pend_pc.size(), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        exp_q.delete();
        drop_cnt   = 0;
        exp_req_pc = 32'h0000_0040;
        tick(1);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1 chk("sc_out_valid", {30'd0, out_valid}, 32'd0);
        chk("sc_inflight_n1", {30'd0, inflight}, 32'd0);
        chk("sc_target_pc", imem_req_pc, 32'h0000_0040);
        fetch_en = 1'b1;
        tick(6);
        drain();

        // Reset mid-run with a full queue.
        do_reset();
        lat = 1;
        tick(1);
        fetch_en = 1'b1;
        ib_stall = 1'b1;
        tick(5);
        chk("mr_full", {30'd0, out_valid}, 32'd3);
        chk("mr_pc_advanced", imem_req_pc, 32'h10);
        do_reset();
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
